nibble_serial_addsub: RTL and testbench
=======================================

# nibble_serial_addsub

Multi-nibble two's-complement add/subtract unit that reuses one 4-bit add/sub slice serially, one nibble per clock, LSB nibble first. It sits upstream of and wraps the team's 4-bit adder datapath. It sequences operands into the slice, chains the carry between nibbles, and collects the sum. It then presents a registered WIDTH-bit result with carry, overflow, zero and negative flags over a valid/ready handshake.

## Interface
- WIDTH, 16, operand/result width in bits.
  - Must be ≥4 and a multiple of 4; any other value is an elaboration error.
  - N = WIDTH/4 nibble steps.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request.
- a  input  WIDTH  minuend/augend.
- b  input  WIDTH  subtrahend/addend.
- sub  input  1  0 = a+b, 1 = a−b.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  sum/difference, modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH−1. For subtract, 1 means no borrow.
- over_flow  output  1  signed overflow.
- zero  output  1  result == 0.
- negative  output  1  result[WIDTH−1].

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- in_ready = (state == IDLE). This is combinational from state only; it does not depend on in_valid.
- IDLE: on in_valid && in_ready, latch a, b and sub into operand registers, clear nibble counter k to 0, and go to RUN.
- RUN, one nibble per cycle:
  - The slice gets a[4k+3:4k] and b[4k+3:4k] XOR {4{sub}}.
  - Slice carry-in is sub when k = 0; otherwise it is the registered carry from nibble k−1.
  - The slice sum is written to result-shadow[4k+3:4k]. The slice carry-out is registered.
  - When k = N−1, the final values are computed:
    - cout_final = slice carry-out.
    - over_flow_final = (carry into bit 3 of the slice) XOR (slice carry-out).
  - After the k = N−1 step, go to DONE.
- DONE: result and the flags are driven from the registered values and out_valid = 1.
  - On out_valid && out_ready, go to IDLE.
  - Outputs hold their values after the handshake until the next completion.
- zero and negative are derived from the completed result and registered together with it.
- Inputs a, b and sub are sampled only at the accept edge. Changes afterwards have no effect on the operation in flight.
- in_valid while not in IDLE is ignored and not queued.
- There is no early termination; every operation takes exactly N RUN cycles.

## Timing
- Reset values: out_valid 0, result 0, cout 0, over_flow 0, zero 0, negative 0, state IDLE, k 0.
  - in_ready reads 1 while in reset and after release.
- Reset assertion is asynchronous and takes effect immediately in any state, including mid-RUN. The partial result is discarded and is not completed after release.
- Let the accept edge be E0. The N RUN steps occur at edges E0+1 … E0+N, so out_valid rises after edge E0+N.
- The output handshake edge Eh returns the FSM to IDLE, so in_ready = 1 in the cycle after Eh. The earliest next accept is at Eh+1.
- Peak throughput is one operation per N+2 cycles (6 cycles for WIDTH = 16).
- Backpressure: while out_ready = 0 in DONE, out_valid and all outputs remain stable and in_ready stays 0.
- Carry into the MSB bit comes from the slice's internal bit-2 carry. It is used only in the last step.

## Structure
- A shared package holds:
  - the FSM state enum (IDLE, RUN, DONE);
  - the NIBBLE_W = 4 constant;
  - a WIDTH-legality check function.
- Sub-module nibble_addsub: a combinational 4-bit ripple add/sub slice.
  - Inputs: a[3:0], b_eff[3:0], cin.
  - Outputs: sum[3:0], cout, c_msb_in (carry into bit 3).
  - It is instantiated exactly once; the top level holds all sequential state.

## Test plan
Directed tests use WIDTH = 16.
- **Add, no flags:** 0x1234 + 0x0FFF, add → result 0x2233, cout 0, over_flow 0, zero 0, negative 0. out_valid rises exactly 4 edges after accept.
- **Add, signed overflow:** 0x7FFF + 0x0001, add → 0x8000, over_flow 1, cout 0, negative 1.
- **Subtract to zero:** 0x0005 − 0x0005 → 0x0000, zero 1, cout 1, over_flow 0.
- **Subtract, signed overflow:** 0x8000 − 0x0001 → 0x7FFF, over_flow 1, cout 1, negative 0.
- **Add, wrap-around:** 0xFFFF + 0x0001 → 0x0000, cout 1, over_flow 0, zero 1.
- **Backpressure and reset:**
  - Hold out_ready = 0 for 5 cycles in DONE → outputs stable, in_ready 0, and a second in_valid is ignored.
  - Then pulse rst_n low during RUN k = 2 of a new operation → out_valid 0, result 0, in_ready 1 immediately.

Source files
------------

// File: rtl/nibble_serial_addsub_pkg.sv
// Shared types and constants for the nibble-serial add/sub unit.
package nibble_serial_addsub_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic bit width_ok(input int w);
        return (w >= NIBBLE_W) && ((w % NIBBLE_W) == 0);
    endfunction

endpackage

// File: rtl/nibble_serial_addsub_if.sv
// Request/response handshake bundle for nibble_serial_addsub.
interface nibble_serial_addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             over_flow;
    logic             zero;
    logic             negative;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, result, cout, over_flow, zero, negative
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, result, cout, over_flow, zero, negative
    );
endinterface

// File: rtl/nibble_serial_addsub_nibble_addsub.sv
// Combinational 4-bit add slice; b_eff arrives already inverted for subtract.
module nibble_addsub
    import nibble_serial_addsub_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b_eff,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout,
    output logic                c_msb_in
);
    logic [NIBBLE_W:0]   full;
    logic [NIBBLE_W-1:0] low;

    assign full = {1'b0, a} + {1'b0, b_eff} + {{NIBBLE_W{1'b0}}, cin};
    // Carry into the top bit: sum of the lower three bits only.
    assign low  = {1'b0, a[NIBBLE_W-2:0]} + {1'b0, b_eff[NIBBLE_W-2:0]}
                + {{(NIBBLE_W-1){1'b0}}, cin};

    assign sum      = full[NIBBLE_W-1:0];
    assign cout     = full[NIBBLE_W];
    assign c_msb_in = low[NIBBLE_W-1];
endmodule

// File: rtl/nibble_serial_addsub.sv
// Multi-nibble add/sub: one shared 4-bit slice, LSB nibble per clock, registered result + flags.
module nibble_serial_addsub
    import nibble_serial_addsub_pkg::*;
#(
    parameter int WIDTH = 16
)(
    input  logic                  clk,
    input  logic                  rst_n,
    nibble_serial_addsub_if.slave bus
);
    localparam int N  = WIDTH / NIBBLE_W;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("nibble_serial_addsub: WIDTH must be >= 4 and a multiple of 4");
    end

    state_t           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, shadow_q, shadow_d, result_q, result_d;
    logic             sub_q, sub_d, carry_q, carry_d;
    logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d, neg_q, neg_d;

    logic [NIBBLE_W-1:0] s_sum, s_b;
    logic                s_cin, s_cout, s_cmsb;
    logic [WIDTH-1:0]    final_res;

    // Operands shift right one nibble per step, so the slice always sees bits [3:0].
    assign s_b   = b_q[NIBBLE_W-1:0] ^ {NIBBLE_W{sub_q}};
    assign s_cin = (k_q == '0) ? sub_q : carry_q;

    nibble_addsub u_slice (
        .a        (a_q[NIBBLE_W-1:0]),
        .b_eff    (s_b),
        .cin      (s_cin),
        .sum      (s_sum),
        .cout     (s_cout),
        .c_msb_in (s_cmsb)
    );

    assign final_res = (WIDTH'(s_sum) << (WIDTH - NIBBLE_W)) | (shadow_q >> NIBBLE_W);

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;
        carry_d  = carry_q;
        shadow_d = shadow_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    sub_d   = bus.sub;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d      = a_q >> NIBBLE_W;
                b_d      = b_q >> NIBBLE_W;
                carry_d  = s_cout;
                shadow_d = final_res;
                k_d      = k_q + KW'(1);
                if (k_q == K_LAST) begin
                    result_d = final_res;
                    cout_d   = s_cout;
                    ovf_d    = s_cmsb ^ s_cout;
                    zero_d   = (final_res == '0);
                    neg_d    = final_res[WIDTH-1];
                    k_d      = '0;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            k_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            carry_q  <= 1'b0;
            shadow_q <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sub_q    <= sub_d;
            carry_q  <= carry_d;
            shadow_q <= shadow_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.cout      = cout_q;
    assign bus.over_flow = ovf_q;
    assign bus.zero      = zero_q;
    assign bus.negative  = neg_q;
endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Bench for nibble_serial_addsub: directed table, handshake/reset corners, random vs. arithmetic model.
module tb_nibble_serial_addsub;
    localparam int W = 16;
    localparam int N = W / 4;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] r;
        logic         c;
        logic         o;
        logic         z;
        logic         n;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    nibble_serial_addsub_if #(.WIDTH(W)) bus ();
    nibble_serial_addsub #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int errors = 0;
    int checks = 0;
    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference built from integer arithmetic on the whole words.
    function automatic vec_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        vec_t   v;
        longint ux, uy, usum, sx, sy, sr;
        ux   = longint'(x);
        uy   = longint'(y);
        usum = s ? ux + ((longint'(1) << W) - uy) : ux + uy;
        sx   = x[W-1] ? ux - (longint'(1) << W) : ux;
        sy   = y[W-1] ? uy - (longint'(1) << W) : uy;
        sr   = s ? sx - sy : sx + sy;
        v.a   = x;
        v.b   = y;
        v.sub = s;
        v.r   = W'(usum % (longint'(1) << W));
        v.c   = (usum >= (longint'(1) << W));
        v.o   = (sr > ((longint'(1) << (W-1)) - 1)) || (sr < -(longint'(1) << (W-1)));
        v.z   = (v.r == '0);
        v.n   = v.r[W-1];
        return v;
    endfunction

    task automatic run_op(input vec_t v, input string tag);
        int n;
        n = 0;
        while (!bus.in_ready && n < 20) begin tick(); n++; end
        chk({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.a = v.a;
        bus.b = v.b;
        bus.sub = v.sub;
        tick();
        bus.in_valid = 1'b0;
        bus.a = W'($urandom);
        bus.b = W'($urandom);
        bus.sub = 1'($urandom);
        n = 0;
        while (!bus.out_valid && n < 20) begin tick(); n++; end
        chk({tag, " latency"}, 32'(n), 32'(N));
        chk({tag, " result"}, 32'(bus.result), 32'(v.r));
        chk({tag, " cout"}, 32'(bus.cout), 32'(v.c));
        chk({tag, " over_flow"}, 32'(bus.over_flow), 32'(v.o));
        chk({tag, " zero"}, 32'(bus.zero), 32'(v.z));
        chk({tag, " negative"}, 32'(bus.negative), 32'(v.n));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, " post out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, " post in_ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, " post hold"}, 32'(bus.result), 32'(v.r));
    endtask

    initial begin
        vec_t v;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.sub = 1'b0;
        bus.out_ready = 1'b0;

        vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};

        #1;
        chk("rst in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst result", 32'(bus.result), 32'd0);
        chk("rst flags", 32'({bus.cout, bus.over_flow, bus.zero, bus.negative}), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) run_op(vecs[i], $sformatf("vec%0d", i));

        // Backpressure: outputs frozen, extra request dropped.
        bus.in_valid = 1'b1;
        bus.a = 16'h1234;
        bus.b = 16'h0FFF;
        bus.sub = 1'b0;
        tick();
        bus.a = 16'h1111;
        bus.b = 16'h2222;
        for (int i = 0; i < N; i++) tick();
        chk("bp out_valid rise", 32'(bus.out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp result", 32'(bus.result), 32'h2233);
            chk("bp flags", 32'({bus.cout, bus.over_flow, bus.zero, bus.negative}), 32'd0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("bp release in_ready", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < N + 2; i++) tick();
        chk("bp not queued", 32'(bus.out_valid), 32'd0);
        chk("bp idle", 32'(bus.in_ready), 32'd1);

        // Reset mid-RUN at k=2 discards the operation.
        bus.in_valid = 1'b1;
        bus.a = 16'hABCD;
        bus.b = 16'h1111;
        bus.sub = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        chk("mid in_ready", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid rst result", 32'(bus.result), 32'd0);
        chk("mid rst in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < N + 2; i++) tick();
        chk("post rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("post rst result", 32'(bus.result), 32'd0);

        for (int i = 0; i < 40; i++) begin
            v = model(W'($urandom), W'($urandom), 1'($urandom));
            run_op(v, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end
endmodule
